led_btn_ctrl: RTL and testbench

Front-panel policy stage directly upstream of the shift-register/button pad interface. It turns a static per-LED mode word into periodic 8-bit shift-register frames (on/off/slow/fast blink) delivered over the `sr_val`/`sr_go`/`sr_rdy` handshake. It also consumes the raw `btn_val`/`btn_stb` sense results and debounces them into a stable button state with press, release and long-press strobes for the CSR/firmware side.

---
 rtl/led_btn_pkg.sv | 39 +++
 rtl/led_btn_ctrl_debounce.sv | 73 +++++++
 rtl/led_btn_ctrl.sv | 104 ++++++++++
 tb/tb_led_btn_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/led_btn_pkg.sv
// Shared LED mode encodings, blink bit positions and the frame composition helper
// for the front-panel LED/button policy stage.
package led_btn_pkg;

    typedef enum logic [1:0] {
        LED_OFF  = 2'b00,
        LED_ON   = 2'b01,
        LED_SLOW = 2'b10,
        LED_FAST = 2'b11
    } led_mode_e;

    typedef enum logic {
        HS_IDLE    = 1'b0,
        HS_PENDING = 1'b1
    } hs_state_e;

    localparam int SLOW_BIT = 4;
    localparam int FAST_BIT = 2;

    // Slow blink follows frame_cnt[4] (16 frames per phase), fast follows frame_cnt[2].
    function automatic logic [7:0] compose_frame(
        input logic [15:0] cfg,
        input logic        en,
        input logic [4:0]  cnt
    );
        logic [7:0] frame;
        frame = 8'h00;
        for (int i = 0; i < 8; i++) begin
            case (led_mode_e'(cfg[2*i +: 2]))
                LED_ON:   frame[i] = 1'b1;
                LED_SLOW: frame[i] = cnt[SLOW_BIT];
                LED_FAST: frame[i] = cnt[FAST_BIT];
                default:  frame[i] = 1'b0;
            endcase
        end
        return en ? frame : 8'h00;
    endfunction

endpackage

// File: rtl/led_btn_ctrl_debounce.sv
// Button debouncer: filters raw sense samples into a stable level and produces
// press, release and once-per-press long-press strobes.
module btn_debounce
    import led_btn_pkg::*;
#(
    parameter int DEBOUNCE_N = 4,
    parameter int LONG_N     = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_val,
    input  logic btn_stb,
    output logic btn_state,
    output logic btn_press_stb,
    output logic btn_release_stb,
    output logic btn_long_stb
);

    localparam logic [7:0] DEB_LIMIT  = 8'(DEBOUNCE_N);
    localparam logic [7:0] LONG_LIMIT = 8'(LONG_N);

    logic [7:0] deb_cnt;
    logic [7:0] hold_cnt;
    logic [7:0] deb_next;
    logic [7:0] hold_next;

    always_comb begin
        deb_next  = deb_cnt + 8'd1;
        hold_next = hold_cnt + 8'd1;
    end

    // Hold counter only counts pressed samples, so the releasing sample can
    // never be the one that completes a long press.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_cnt         <= 8'd0;
            hold_cnt        <= 8'd0;
            btn_state       <= 1'b0;
            btn_press_stb   <= 1'b0;
            btn_release_stb <= 1'b0;
            btn_long_stb    <= 1'b0;
        end else begin
            btn_press_stb   <= 1'b0;
            btn_release_stb <= 1'b0;
            btn_long_stb    <= 1'b0;
            if (btn_stb) begin
                if (btn_val == btn_state) begin
                    deb_cnt <= 8'd0;
                end else if (deb_next == DEB_LIMIT) begin
                    deb_cnt   <= 8'd0;
                    btn_state <= btn_val;
                    if (btn_val) begin
                        btn_press_stb <= 1'b1;
                    end else begin
                        btn_release_stb <= 1'b1;
                    end
                end else begin
                    deb_cnt <= deb_next;
                end

                if (!btn_state && btn_val && deb_next == DEB_LIMIT) begin
                    hold_cnt <= 8'd0;
                end else if (btn_state && btn_val && hold_cnt != LONG_LIMIT) begin
                    hold_cnt <= hold_next;
                    if (hold_next == LONG_LIMIT) begin
                        btn_long_stb <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/led_btn_ctrl.sv
// Front-panel policy stage: periodic LED frames toward the shift-register pad
// interface, plus debounced button state and strobes for the CSR side.
module led_btn_ctrl
    import led_btn_pkg::*;
#(
    parameter int REFRESH_LOG2 = 14,
    parameter int DEBOUNCE_N   = 4,
    parameter int LONG_N       = 100
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] led_cfg,
    input  logic        led_en,
    output logic [7:0]  sr_val,
    output logic        sr_go,
    input  logic        sr_rdy,
    input  logic        btn_val,
    input  logic        btn_stb,
    output logic        btn_state,
    output logic        btn_press_stb,
    output logic        btn_release_stb,
    output logic        btn_long_stb
);

    localparam logic [REFRESH_LOG2-1:0] PRESC_ONE = REFRESH_LOG2'(1);

    logic [REFRESH_LOG2-1:0] presc;
    logic                    tick;
    logic [4:0]              frame_cnt;
    logic [4:0]              frame_next;
    hs_state_e               hs_state;
    hs_state_e               hs_next;

    // tick is registered so it is high exactly while the prescaler sits at 0 after a wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            tick  <= 1'b0;
        end else begin
            presc <= presc + PRESC_ONE;
            tick  <= (presc == '1);
        end
    end

    assign frame_next = frame_cnt + 5'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= 5'd0;
            sr_val    <= 8'h00;
        end else if (tick) begin
            frame_cnt <= frame_next;
            sr_val    <= compose_frame(led_cfg, led_en, frame_next);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hs_state <= HS_IDLE;
        end else begin
            hs_state <= hs_next;
        end
    end

    // A tick always leaves a frame pending, even if the old one is accepted on the same edge.
    always_comb begin
        hs_next = hs_state;
        case (hs_state)
            HS_IDLE: begin
                if (tick) begin
                    hs_next = HS_PENDING;
                end
            end
            HS_PENDING: begin
                if (!tick && sr_rdy) begin
                    hs_next = HS_IDLE;
                end
            end
            default: hs_next = HS_IDLE;
        endcase
    end

    always_comb begin
        sr_go = 1'b0;
        if (hs_state == HS_PENDING) begin
            sr_go = 1'b1;
        end
    end

    btn_debounce #(
        .DEBOUNCE_N (DEBOUNCE_N),
        .LONG_N     (LONG_N)
    ) u_btn_debounce (
        .clk             (clk),
        .rst             (rst),
        .btn_val         (btn_val),
        .btn_stb         (btn_stb),
        .btn_state       (btn_state),
        .btn_press_stb   (btn_press_stb),
        .btn_release_stb (btn_release_stb),
        .btn_long_stb    (btn_long_stb)
    );

endmodule

// File: tb/tb_led_btn_ctrl.sv
// Directed bench for led_btn_ctrl: frame cadence, blink patterns, handshake
// back-pressure and coincidence, debounce, long press and mid-hold reset.
module tb_led_btn_ctrl;

    logic        clk;
    logic        rst;
    logic [15:0] led_cfg;
    logic        led_en;
    logic [7:0]  sr_val;
    logic        sr_go;
    logic        sr_rdy;
    logic        btn_val;
    logic        btn_stb;
    logic        btn_state;
    logic        btn_press_stb;
    logic        btn_release_stb;
    logic        btn_long_stb;
    logic [3:0]  btn_bus;

    int          checks = 0;
    int          passes = 0;
    int          acc_count = 0;
    logic [7:0]  accepted = 8'h00;
    int          f;
    int          cyc;
    int          acc_before;
    int          gaps;
    logic        pat [7];

    led_btn_ctrl #(
        .REFRESH_LOG2 (4),
        .DEBOUNCE_N   (4),
        .LONG_N       (10)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .led_cfg         (led_cfg),
        .led_en          (led_en),
        .sr_val          (sr_val),
        .sr_go           (sr_go),
        .sr_rdy          (sr_rdy),
        .btn_val         (btn_val),
        .btn_stb         (btn_stb),
        .btn_state       (btn_state),
        .btn_press_stb   (btn_press_stb),
        .btn_release_stb (btn_release_stb),
        .btn_long_stb    (btn_long_stb)
    );

    assign btn_bus = {btn_state, btn_press_stb, btn_release_stb, btn_long_stb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Downstream shifter model: records what was actually transferred.
    always @(posedge clk) begin
        if (sr_go && sr_rdy) begin
            accepted  <= sr_val;
            acc_count <= acc_count + 1;
        end
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [7:0] exp_frame(input int n);
        logic [4:0] c;
        c = n[4:0];
        return {(c[2] ? 4'hF : 4'h0), (c[4] ? 4'hF : 4'h0)};
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
            $error("[TB] check %s did not match", tag);
        end
    endtask

    task automatic applyStimulus(input logic val);
        btn_val = val;
        btn_stb = 1'b1;
        @(negedge clk);
        btn_stb = 1'b0;
    endtask

    task automatic wait_frame(output int n);
        n = 1;
        @(negedge clk);
        while (!sr_go && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        led_cfg = 16'h0001;
        led_en  = 1'b1;
        sr_rdy  = 1'b1;
        btn_val = 1'b0;
        btn_stb = 1'b0;
        pat     = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        repeat (3) @(negedge clk);

        checkOutput("reset_sr_val", 32'(sr_val), 32'h0);
        checkOutput("reset_sr_go", 32'(sr_go), 32'h0);
        checkOutput("reset_btn_outputs", 32'(btn_bus), 32'h0);

        rst = 1'b0;
        wait_frame(cyc);
        checkOutput("first_frame_latency", 32'(cyc), 32'd17);
        checkOutput("first_frame_value", 32'(sr_val), 32'h01);
        f = 1;
        wait_frame(cyc);
        checkOutput("frame_period", 32'(cyc), 32'd16);
        checkOutput("second_frame_value", 32'(sr_val), 32'h01);
        f = 2;

        led_en = 1'b0;
        wait_frame(cyc);
        checkOutput("led_en_off_frame", 32'(sr_val), 32'h00);
        f = 3;

        led_cfg = 16'hFFAA;
        led_en  = 1'b1;
        for (int k = 0; k < 32; k++) begin
            wait_frame(cyc);
            f = (f + 1) % 32;
            checkOutput("blink_frame", 32'(sr_val), 32'(exp_frame(f)));
        end

        sr_rdy     = 1'b0;
        acc_before = acc_count;
        gaps       = 0;
        repeat (48) begin
            @(negedge clk);
            if (!sr_go) gaps++;
        end
        f = (f + 3) % 32;
        checkOutput("stall_go_held", 32'(gaps), 32'd0);
        checkOutput("stall_latest_frame", 32'(sr_val), 32'(exp_frame(f)));
        checkOutput("stall_no_accept", 32'(acc_count), 32'(acc_before));
        sr_rdy = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("stall_single_accept", 32'(acc_count), 32'(acc_before + 1));
        checkOutput("stall_accepted_value", 32'(accepted), 32'(exp_frame(f)));
        checkOutput("stall_go_cleared", 32'(sr_go), 32'h0);

        sr_rdy = 1'b0;
        repeat (6) @(negedge clk);
        f = (f + 1) % 32;
        checkOutput("coinc_pending", 32'(sr_go), 32'h1);
        checkOutput("coinc_old_frame", 32'(sr_val), 32'(exp_frame(f)));
        repeat (15) @(negedge clk);
        sr_rdy     = 1'b1;
        acc_before = acc_count;
        @(negedge clk);
        checkOutput("coinc_accepted_old", 32'(accepted), 32'(exp_frame(f)));
        checkOutput("coinc_accept_count", 32'(acc_count), 32'(acc_before + 1));
        f = (f + 1) % 32;
        checkOutput("coinc_go_stays", 32'(sr_go), 32'h1);
        checkOutput("coinc_new_frame", 32'(sr_val), 32'(exp_frame(f)));
        @(negedge clk);
        checkOutput("coinc_go_after", 32'(sr_go), 32'h0);
        checkOutput("coinc_second_accept", 32'(acc_count), 32'(acc_before + 2));

        for (int i = 0; i < 7; i++) begin
            applyStimulus(pat[i]);
            checkOutput("debounce_press", 32'(btn_bus), (i == 6) ? 32'b1100 : 32'b0000);
        end
        for (int i = 1; i <= 11; i++) begin
            applyStimulus(1'b1);
            checkOutput("long_hold", 32'(btn_bus), (i == 10) ? 32'b1001 : 32'b1000);
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0);
            checkOutput("long_release", 32'(btn_bus), (i == 4) ? 32'b0010 : 32'b1000);
        end
        @(negedge clk);
        checkOutput("idle_after_release", 32'(btn_bus), 32'b0000);

        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b1);
            checkOutput("short_press", 32'(btn_bus), (i == 4) ? 32'b1100 : 32'b0000);
        end
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(1'b1);
            checkOutput("short_hold", 32'(btn_bus), 32'b1000);
        end
        for (int i = 1; i <= 4; i++) begin
            applyStimulus(1'b0);
            checkOutput("short_release", 32'(btn_bus), (i == 4) ? 32'b0010 : 32'b1000);
        end

        sr_rdy = 1'b0;
        cyc    = 0;
        while (!sr_go && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("pending_before_reset", 32'(sr_go), 32'h1);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1);
        end
        checkOutput("pressed_before_reset", 32'(btn_state), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_sr_go", 32'(sr_go), 32'h0);
        checkOutput("midreset_sr_val", 32'(sr_val), 32'h0);
        checkOutput("midreset_btn_outputs", 32'(btn_bus), 32'h0);
        rst    = 1'b0;
        sr_rdy = 1'b1;
        wait_frame(cyc);
        checkOutput("post_reset_latency", 32'(cyc), 32'd17);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
